// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle IEEE-754 single-precision add/subtract behind valid/ready handshakes
module fp_addsub_seq #(
    parameter logic [31:0] QNAN        = 32'h7FC00000,
    parameter int unsigned ALIGN_CLAMP = 25
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sign,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] Result,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow
);
    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, PACK, RESP} state_t;
    localparam logic [7:0] CLAMP = 8'(ALIGN_CLAMP);
    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [24:0]       sig_q, sig_d, sum;
    logic [23:0]       sml_q, sml_d, sig_a, sig_b;
    logic signed [9:0] exp_q, exp_d;
    logic [7:0]        diff_q, diff_d;
    logic              sgn_q, sgn_d, sub_q, sub_d;
    logic              exc_q, exc_d, ovf_q, ovf_d, unf_q, unf_d;
    logic              a_big, clamp;
    assign sig_a      = (a_q[30:23] == 8'h00) ? 24'h0 : {1'b1, a_q[22:0]};
    assign sig_b      = (b_q[30:23] == 8'h00) ? 24'h0 : {1'b1, b_q[22:0]};
    assign a_big      = {a_q[30:23], sig_a} >= {b_q[30:23], sig_b};
    assign sum        = sub_q ? sig_q - {1'b0, sml_q} : sig_q + {1'b0, sml_q};
    assign clamp      = diff_q >= CLAMP;
    assign req_ready  = rst_n && state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign Result     = res_q;
    assign Exception  = exc_q;
    assign Overflow   = ovf_q;
    assign Underflow  = unf_q;
    // next state and datapath update for each step of the operation; b_q holds B with the effective sign
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sig_d   = sig_q;
        sml_d   = sml_q;
        exp_d   = exp_q;
        diff_d  = diff_q;
        sgn_d   = sgn_q;
        sub_d   = sub_q;
        exc_d   = exc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: if (req_valid) begin
                a_d     = A;
                b_d     = {B[31] ^ sign, B[30:0]};
                exc_d   = 1'b0;
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                state_d = UNPACK;
            end
            UNPACK: if (&a_q[30:23] || &b_q[30:23]) begin
                res_d   = QNAN;
                exc_d   = 1'b1;
                state_d = RESP;
            end else begin
                sig_d   = {1'b0, a_big ? sig_a : sig_b};
                sml_d   = a_big ? sig_b : sig_a;
                exp_d   = {2'b00, a_big ? a_q[30:23] : b_q[30:23]};
                diff_d  = a_big ? a_q[30:23] - b_q[30:23] : b_q[30:23] - a_q[30:23];
                sgn_d   = a_big ? a_q[31] : b_q[31];
                sub_d   = a_q[31] ^ b_q[31];
                state_d = ALIGN;
            end
            ALIGN: begin
                sml_d   = clamp ? 24'h0 : (diff_q == 8'h00) ? sml_q : sml_q >> 1;
                diff_d  = (clamp || diff_q == 8'h00) ? 8'h00 : diff_q - 8'h01;
                state_d = (clamp || diff_q <= 8'h01) ? ADD : ALIGN;
            end
            ADD: begin
                sig_d   = sum[24] ? sum >> 1 : sum;
                exp_d   = sum[24] ? exp_q + 10'sd1 : exp_q;
                res_d   = (sum == 25'h0) ? 32'h0 : res_q;
                state_d = (sum == 25'h0) ? RESP : (sum[24] || sum[23]) ? PACK : NORM;
            end
            NORM: begin
                sig_d   = sig_q << 1;
                exp_d   = exp_q - 10'sd1;
                state_d = sig_q[22] ? PACK : NORM;
            end
            PACK: begin
                ovf_d   = exp_q > 10'sd254;
                unf_d   = exp_q < 10'sd1;
                res_d   = ovf_d ? {sgn_q, 8'hFF, 23'h0} : unf_d ? {sgn_q, 31'h0} : {sgn_q, exp_q[7:0], sig_q[22:0]};
                state_d = RESP;
            end
            RESP: state_d = resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    // state and datapath registers, cleared by asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sig_q   <= '0;
            sml_q   <= '0;
            exp_q   <= '0;
            diff_q  <= '0;
            sgn_q   <= 1'b0;
            sub_q   <= 1'b0;
            exc_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sig_q   <= sig_d;
            sml_q   <= sml_d;
            exp_q   <= exp_d;
            diff_q  <= diff_d;
            sgn_q   <= sgn_d;
            sub_q   <= sub_d;
            exc_q   <= exc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end
endmodule
